// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cam_pkg
// Purpose : Shared encodings for the camera frame classifier: result codes,
//           controller states and RGB565 field positions, plus the colour
//           dominance test used per pixel.
// Revision: 1.0 - initial release
// ============================================================================
package cam_pkg;

  // One-hot colour result codes
  localparam logic [2:0] RES_NONE  = 3'b000;
  localparam logic [2:0] RES_RED   = 3'b001;
  localparam logic [2:0] RES_GREEN = 3'b010;
  localparam logic [2:0] RES_BLUE  = 3'b100;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_VS = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_EVAL    = 3'd3,
    ST_REPORT  = 3'd4
  } state_t;

  // Field positions inside the 16-bit pixel word {byte0, byte1}
  localparam int unsigned PX_R_LSB = 11;  // R[4:0] at [15:11]
  localparam int unsigned PX_G_LSB = 5;   // G[5:0] at [10:5]
  localparam int unsigned PX_B_LSB = 0;   // B[4:0] at [4:0]

  // True when c beats both a and b by at least thresh. The sums are kept
  // wider than the operands so a large margin can never wrap around.
  function automatic logic dominates(input logic [4:0] c, input logic [4:0] a,
                                     input logic [4:0] b, input logic [5:0] thresh);
    logic [6:0] c_w;
    c_w = {2'b00, c};
    dominates = (c_w >= ({2'b00, a} + {1'b0, thresh})) &&
                (c_w >= ({2'b00, b} + {1'b0, thresh}));
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : cam_sync_edge
// Purpose : Two-flop synchronisers for the camera timing and data lines, with
//           edge detection on the synchronised pclk, href and vsync.
// Revision: 1.0 - initial release
// ============================================================================
module cam_sync_edge (
  input  logic       clk,
  input  logic       rst_n_i,
  input  logic       pclk_i,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] data_i,
  output logic       href_o,
  output logic [7:0] data_o,
  output logic       pclk_rise_o,
  output logic       href_fall_o,
  output logic       vsync_rise_o,
  output logic       vsync_fall_o
);

  // [0] metastable stage, [1] synchronised level, [2] previous synced level
  logic [2:0] pclk_q;
  logic [2:0] href_q;
  logic [2:0] vsync_q;
  logic [7:0] data_meta_q;
  logic [7:0] data_sync_q;

  // Shift the raw inputs through the synchroniser and history stages
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pclk_q      <= '0;
      href_q      <= '0;
      vsync_q     <= '0;
      data_meta_q <= '0;
      data_sync_q <= '0;
    end else begin
      pclk_q      <= {pclk_q[1:0], pclk_i};
      href_q      <= {href_q[1:0], href_i};
      vsync_q     <= {vsync_q[1:0], vsync_i};
      data_meta_q <= data_i;
      data_sync_q <= data_meta_q;
    end
  end

  // Data travels with pclk through the same depth, so a detected pclk rise
  // sees the byte that was stable while pclk was low.
  assign href_o       = href_q[1];
  assign data_o       = data_sync_q;
  assign pclk_rise_o  = pclk_q[1] & ~pclk_q[2];
  assign href_fall_o  = ~href_q[1] & href_q[2];
  assign vsync_rise_o = vsync_q[1] & ~vsync_q[2];
  assign vsync_fall_o = ~vsync_q[1] & vsync_q[2];

endmodule
`default_nettype wire

// File: rtl/cam_frame_classifier.sv
`default_nettype none
// ============================================================================
// Module  : cam_frame_classifier
// Purpose : Captures RGB565 camera frames, counts red/green/blue dominant
//           pixels over N_FRAMES frames and reports the majority colour.
//           Define CAM_ROI_EN to restrict counting to the ROI_* window.
// Revision: 1.0 - initial release
// ============================================================================
module cam_frame_classifier
  import cam_pkg::*;
#(
  parameter int unsigned CAM_SCREEN_X = 160,
  parameter int unsigned CAM_SCREEN_Y = 120,
  parameter int unsigned N_FRAMES     = 1,
  parameter int unsigned COLOR_THRESH = 4,
  parameter int unsigned ROI_X0       = 0,
  parameter int unsigned ROI_X1       = 159,
  parameter int unsigned ROI_Y0       = 0,
  parameter int unsigned ROI_Y1       = 119
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CAM_pclk,
  input  logic       CAM_vsync,
  input  logic       CAM_href,
  input  logic [7:0] CAM_px_data,
  input  logic       init,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] res
);

  localparam int unsigned CNT_W  = $clog2(N_FRAMES * CAM_SCREEN_X * CAM_SCREEN_Y + 1);
  localparam int unsigned COL_W  = $clog2(CAM_SCREEN_X + 1);
  localparam int unsigned LINE_W = $clog2(CAM_SCREEN_Y + 1);
  localparam int unsigned FRM_W  = 5;
  localparam logic [COL_W-1:0]  COL_FULL  = COL_W'(CAM_SCREEN_X);
  localparam logic [LINE_W-1:0] LINE_FULL = LINE_W'(CAM_SCREEN_Y);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(N_FRAMES - 1);
  localparam logic [5:0]        THRESH    = 6'(COLOR_THRESH);

  state_t              state_q;
  logic [7:0]          byte0_q;
  logic                phase_q;      // 1 while waiting for the second byte
  logic [COL_W-1:0]    col_q;
  logic [LINE_W-1:0]   line_q;
  logic                shape_err_q;  // sticky bad line width / line count
  logic [FRM_W-1:0]    frame_q;
  logic [CNT_W-1:0]    red_q, green_q, blue_q, total_q;
  logic [2:0]          win_q, res_q;
  logic                done_q, error_q;

  logic                href_s, pclk_rise, href_fall, vsync_rise, vsync_fall;
  logic [7:0]          data_s;

  cam_sync_edge u_sync (
    .clk          (clk),
    .rst_n_i      (rst),
    .pclk_i       (CAM_pclk),
    .vsync_i      (CAM_vsync),
    .href_i       (CAM_href),
    .data_i       (CAM_px_data),
    .href_o       (href_s),
    .data_o       (data_s),
    .pclk_rise_o  (pclk_rise),
    .href_fall_o  (href_fall),
    .vsync_rise_o (vsync_rise),
    .vsync_fall_o (vsync_fall)
  );

  logic [15:0]       w_pixel;
  logic [4:0]        w_r, w_g, w_b;
  logic              w_byte, w_px_done, w_in_roi, w_count;
  logic              w_line_bad, w_shape_err, w_frame_bad;
  logic [LINE_W-1:0] w_lines;
  logic [CNT_W-1:0]  w_quarter;
  logic [2:0]        w_win;

  assign w_pixel   = {byte0_q, data_s};
  assign w_r       = w_pixel[PX_R_LSB +: 5];
  assign w_g       = w_pixel[PX_G_LSB + 1 +: 5];   // G compared as G[5:1]
  assign w_b       = w_pixel[PX_B_LSB +: 5];
  assign w_byte    = (state_q == ST_CAPTURE) && pclk_rise && href_s;
  assign w_px_done = w_byte && phase_q;

`ifdef CAM_ROI_EN
  assign w_in_roi = (32'(col_q) >= ROI_X0) && (32'(col_q) <= ROI_X1) &&
                    (32'(line_q) >= ROI_Y0) && (32'(line_q) <= ROI_Y1);
`else
  assign w_in_roi = 1'b1;
`endif

  assign w_count = w_px_done && w_in_roi;

  // Frame shape tracking; folding in this cycle's href fall keeps the check
  // correct even if vsync rises on the same clock as the last line ends.
  assign w_line_bad  = href_fall && (phase_q || (col_q != COL_FULL) || (line_q == LINE_FULL));
  assign w_shape_err = shape_err_q || w_line_bad || (w_px_done && (col_q == COL_FULL));
  assign w_lines     = (href_fall && (line_q != LINE_FULL)) ? line_q + LINE_W'(1) : line_q;
  assign w_frame_bad = w_shape_err || (w_lines != LINE_FULL);

  // Majority decision: strictly largest counter that also beats a quarter
  always_comb begin
    w_quarter = total_q >> 2;
    w_win     = RES_NONE;
    if (red_q > green_q && red_q > blue_q && red_q > w_quarter)
      w_win = RES_RED;
    else if (green_q > red_q && green_q > blue_q && green_q > w_quarter)
      w_win = RES_GREEN;
    else if (blue_q > red_q && blue_q > green_q && blue_q > w_quarter)
      w_win = RES_BLUE;
  end

  // Control FSM with pixel assembly, counting and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      byte0_q     <= '0;
      phase_q     <= 1'b0;
      col_q       <= '0;
      line_q      <= '0;
      shape_err_q <= 1'b0;
      frame_q     <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      total_q     <= '0;
      win_q       <= RES_NONE;
      res_q       <= RES_NONE;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (init) begin
            state_q <= ST_WAIT_VS;
            frame_q <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            total_q <= '0;
          end
        end
        ST_WAIT_VS: begin
          if (vsync_fall) begin
            state_q     <= ST_CAPTURE;
            col_q       <= '0;
            line_q      <= '0;
            phase_q     <= 1'b0;
            shape_err_q <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (w_byte) begin
            if (!phase_q) begin
              byte0_q <= data_s;
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (col_q != COL_FULL) col_q <= col_q + COL_W'(1);
            end
          end
          if (w_count) begin
            total_q <= total_q + CNT_W'(1);
            if (dominates(w_r, w_g, w_b, THRESH))      red_q   <= red_q + CNT_W'(1);
            else if (dominates(w_g, w_r, w_b, THRESH)) green_q <= green_q + CNT_W'(1);
            else if (dominates(w_b, w_r, w_g, THRESH)) blue_q  <= blue_q + CNT_W'(1);
          end
          if (href_fall) begin
            col_q   <= '0;
            phase_q <= 1'b0;  // an odd trailing byte is dropped here
          end
          line_q      <= w_lines;
          shape_err_q <= w_shape_err;
          if (vsync_rise) begin
            if (w_frame_bad) begin
              error_q <= 1'b1;
              res_q   <= RES_NONE;
              state_q <= ST_IDLE;
            end else begin
              frame_q <= frame_q + FRM_W'(1);
              state_q <= (frame_q == FRM_LAST) ? ST_EVAL : ST_WAIT_VS;
            end
          end
        end
        ST_EVAL: begin
          win_q   <= w_win;
          state_q <= ST_REPORT;
        end
        ST_REPORT: begin
          res_q   <= win_q;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign error = error_q;
  assign res   = res_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_frame_classifier.sv
`default_nettype none
// ============================================================================
// Module  : tb_cam_frame_classifier
// Purpose : Directed self-checking bench for cam_frame_classifier using a
//           reduced 16x12 screen; one instance accumulates 1 frame, the other
//           2 frames, both fed from the same camera stream.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cam_frame_classifier;

  localparam int SX = 16;
  localparam int SY = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       pclk, vsync, href;
  logic [7:0] pxd;
  logic       init1, init2;
  logic       busy1, done1, error1;
  logic       busy2, done2, error2;
  logic [2:0] res1, res2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cam_frame_classifier #(
    .CAM_SCREEN_X(SX), .CAM_SCREEN_Y(SY), .N_FRAMES(1), .COLOR_THRESH(4),
    .ROI_X0(4), .ROI_X1(11), .ROI_Y0(3), .ROI_Y1(8)
  ) u_dut1 (
    .clk(clk), .rst(rst), .CAM_pclk(pclk), .CAM_vsync(vsync), .CAM_href(href),
    .CAM_px_data(pxd), .init(init1), .busy(busy1), .done(done1),
    .error(error1), .res(res1)
  );

  cam_frame_classifier #(
    .CAM_SCREEN_X(SX), .CAM_SCREEN_Y(SY), .N_FRAMES(2), .COLOR_THRESH(4),
    .ROI_X0(4), .ROI_X1(11), .ROI_Y0(3), .ROI_Y1(8)
  ) u_dut2 (
    .clk(clk), .rst(rst), .CAM_pclk(pclk), .CAM_vsync(vsync), .CAM_href(href),
    .CAM_px_data(pxd), .init(init2), .busy(busy2), .done(done2),
    .error(error2), .res(res2)
  );

  // kind: 0 red, 1 blue, 2 green, 3 grey, 4 red window inside blue
  function automatic logic [15:0] pix(int kind, int line, int col);
    case (kind)
      0:       pix = 16'hF800;
      1:       pix = 16'h001F;
      2:       pix = 16'h07E0;
      3:       pix = 16'h8410;
      default: pix = (col >= 4 && col <= 11 && line >= 3 && line <= 8) ? 16'hF800 : 16'h001F;
    endcase
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(logic [7:0] b);
    pxd  = b;
    pclk = 1'b0;
    tick(3);
    pclk = 1'b1;
    tick(3);
  endtask

  // odd_line >= 0 appends one stray byte to that line
  task automatic send_frame(int kind, int n_lines, int odd_line);
    logic [15:0] p;
    vsync = 1'b1;
    tick(8);
    vsync = 1'b0;
    tick(8);
    for (int l = 0; l < n_lines; l++) begin
      href = 1'b1;
      tick(2);
      for (int c = 0; c < SX; c++) begin
        p = pix(kind, l, c);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
      end
      if (l == odd_line) send_byte(8'hAA);
      pclk = 1'b0;
      tick(3);
      href = 1'b0;
      tick(6);
    end
    vsync = 1'b1;
    tick(1);
  endtask

  // Watch one instance for a bounded window, counting done/error pulses and
  // capturing res/busy at the last pulse; any done drops both init lines.
  task automatic wait_result(input bit sel2, output int n_done, output int n_err,
                             output logic [2:0] r_at, output logic b_at);
    n_done = 0;
    n_err  = 0;
    r_at   = 3'b111;
    b_at   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (sel2 ? done2 : done1) begin
        n_done++;
        r_at  = sel2 ? res2 : res1;
        b_at  = sel2 ? busy2 : busy1;
        init1 = 1'b0;
        init2 = 1'b0;
      end
      if (sel2 ? error2 : error1) begin
        n_err++;
        r_at = sel2 ? res2 : res1;
        b_at = sel2 ? busy2 : busy1;
      end
    end
  endtask

  task automatic pulse_init(bit sel2);
    if (sel2) init2 = 1'b1; else init1 = 1'b1;
    tick(1);
    init1 = 1'b0;
    init2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; pclk = 1'b0; vsync = 1'b0; href = 1'b0; pxd = 8'h00;
    init1 = 1'b0; init2 = 1'b0;
    tick(3);
    checks++; if (busy1 !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    checks++; if (done1 !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", done1); end
    checks++; if (error1 !== 1'b0)  begin errors++; $display("FAIL reset_error: got %b expected 0", error1); end
    checks++; if (res1 !== 3'b000)  begin errors++; $display("FAIL reset_res: got %b expected 000", res1); end
    rst = 1'b1;
    tick(3);
    checks++; if (busy2 !== 1'b0)   begin errors++; $display("FAIL idle_busy2: got %b expected 0", busy2); end
  endtask

  task automatic test_red_frame();
    int nd, ne; logic [2:0] r; logic b;
    pulse_init(1'b0);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL red_busy: got %b expected 1", busy1); end
    send_frame(0, SY, -1);
    wait_result(1'b0, nd, ne, r, b);
    checks++; if (nd !== 1)      begin errors++; $display("FAIL red_done_count: got %0d expected 1", nd); end
    checks++; if (ne !== 0)      begin errors++; $display("FAIL red_error_count: got %0d expected 0", ne); end
    checks++; if (r !== 3'b001)  begin errors++; $display("FAIL red_res: got %b expected 001", r); end
  endtask

  task automatic test_short_frame();
    int nd, ne; logic [2:0] r; logic b;
    pulse_init(1'b0);
    checks++; if (res1 !== 3'b001) begin errors++; $display("FAIL res_hold: got %b expected 001", res1); end
    send_frame(0, SY - 1, -1);
    wait_result(1'b0, nd, ne, r, b);
    checks++; if (ne !== 1)      begin errors++; $display("FAIL short_error_count: got %0d expected 1", ne); end
    checks++; if (nd !== 0)      begin errors++; $display("FAIL short_done_count: got %0d expected 0", nd); end
    checks++; if (r !== 3'b000)  begin errors++; $display("FAIL short_res: got %b expected 000", r); end
    checks++; if (b !== 1'b0)    begin errors++; $display("FAIL short_busy: got %b expected 0", b); end
  endtask

  task automatic test_odd_byte();
    int nd, ne; logic [2:0] r; logic b;
    pulse_init(1'b0);
    send_frame(0, SY, 5);
    wait_result(1'b0, nd, ne, r, b);
    checks++; if (ne !== 1) begin errors++; $display("FAIL odd_error_count: got %0d expected 1", ne); end
    checks++; if (nd !== 0) begin errors++; $display("FAIL odd_done_count: got %0d expected 0", nd); end
  endtask

  task automatic test_multi_frame(int k1, int k2, logic [2:0] exp_res, string tag);
    int nd, ne; logic [2:0] r; logic b;
    pulse_init(1'b1);
    send_frame(k1, SY, -1);
    wait_result(1'b1, nd, ne, r, b);
    checks++; if (nd + ne !== 0) begin errors++; $display("FAIL %s_first_frame_pulses: got %0d expected 0", tag, nd + ne); end
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL %s_busy_between: got %b expected 1", tag, busy2); end
    send_frame(k2, SY, -1);
    wait_result(1'b1, nd, ne, r, b);
    checks++; if (nd !== 1)       begin errors++; $display("FAIL %s_done_count: got %0d expected 1", tag, nd); end
    checks++; if (r !== exp_res)  begin errors++; $display("FAIL %s_res: got %b expected %b", tag, r, exp_res); end
  endtask

  task automatic test_roi();
    int nd, ne; logic [2:0] r; logic b; logic [2:0] exp_res;
`ifdef CAM_ROI_EN
    exp_res = 3'b001;
`else
    exp_res = 3'b100;
`endif
    pulse_init(1'b0);
    send_frame(4, SY, -1);
    wait_result(1'b0, nd, ne, r, b);
    checks++; if (nd !== 1)      begin errors++; $display("FAIL roi_done_count: got %0d expected 1", nd); end
    checks++; if (r !== exp_res) begin errors++; $display("FAIL roi_res: got %b expected %b", r, exp_res); end
  endtask

  task automatic test_reset_mid_frame();
    int nd, ne; logic [2:0] r; logic b;
    pulse_init(1'b0);
    vsync = 1'b1; tick(8);
    vsync = 1'b0; tick(8);
    href = 1'b1; tick(2);
    for (int i = 0; i < 5; i++) send_byte(8'hF8);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy1); end
    rst = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b0)  begin errors++; $display("FAIL mid_busy: got %b expected 0", busy1); end
    checks++; if (done1 !== 1'b0)  begin errors++; $display("FAIL mid_done: got %b expected 0", done1); end
    checks++; if (error1 !== 1'b0) begin errors++; $display("FAIL mid_error: got %b expected 0", error1); end
    checks++; if (res1 !== 3'b000) begin errors++; $display("FAIL mid_res: got %b expected 000", res1); end
    tick(2);
    pclk = 1'b0; href = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(3);
    pulse_init(1'b0);
    send_frame(3, SY, -1);
    wait_result(1'b0, nd, ne, r, b);
    checks++; if (nd !== 1)     begin errors++; $display("FAIL grey_done_count: got %0d expected 1", nd); end
    checks++; if (r !== 3'b000) begin errors++; $display("FAIL grey_res: got %b expected 000", r); end
  endtask

  task automatic test_init_held();
    int nd, ne; logic [2:0] r; logic b;
    init1 = 1'b1;
    tick(1);
    send_frame(0, SY, -1);
    wait_result(1'b0, nd, ne, r, b);
    init1 = 1'b0;
    checks++; if (nd !== 1)       begin errors++; $display("FAIL held_done_count: got %0d expected 1", nd); end
    checks++; if (r !== 3'b001)   begin errors++; $display("FAIL held_res: got %b expected 001", r); end
    tick(5);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL held_busy_after: got %b expected 0", busy1); end
  endtask

  initial begin
    test_reset();
    test_red_frame();
    test_short_frame();
    test_odd_byte();
    test_multi_frame(1, 2, 3'b000, "tie");
    test_multi_frame(2, 3, 3'b010, "green_grey");
    test_roi();
    test_reset_mid_frame();
    test_init_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cam_frame_classifier.md
CAM_FRAME_CLASSIFIER -- requirements
Module: cam_frame_classifier

Interface
REQ-001 SHALL have parameter CAM_SCREEN_X, default 160, pixels per line.
REQ-002 SHALL have parameter CAM_SCREEN_Y, default 120, lines per frame.
REQ-003 SHALL have parameter N_FRAMES, default 1, frames accumulated per result (1..16).
REQ-004 SHALL have parameter COLOR_THRESH, default 4, margin a channel needs over both others for a pixel to count as that colour.
REQ-005 SHALL have parameters ROI_X0/ROI_X1/ROI_Y0/ROI_Y1, defaults 0/159/0/119, inclusive region of interest.
REQ-006 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports CAM_pclk, CAM_vsync, CAM_href, inputs, 1 each, raw camera timing (asynchronous to clk).
REQ-009 SHALL have port CAM_px_data, input, 8, raw camera byte.
REQ-010 SHALL have port init, input, 1, start request (level sampled per clk).
REQ-011 SHALL have ports busy, done, error, outputs, 1 each; done and error are one-cycle pulses.
REQ-012 SHALL have port res, output, 3, result: 001 red, 010 green, 100 blue, 000 none.

Function
REQ-013 SHALL pass CAM_pclk/vsync/href/px_data through 2-flop synchronisers and capture a byte on each detected rising edge of synced pclk while synced href is high; clk SHALL be at least 4x pclk.
REQ-014 SHALL use states IDLE, WAIT_VS, CAPTURE, EVAL, REPORT.
REQ-015 IDLE -> WAIT_VS when init=1; busy=1 in every state except IDLE.
REQ-016 WAIT_VS -> CAPTURE on the first synced vsync falling edge; clear column/line counters.
REQ-017 Pixel = two bytes RGB565, byte0={R[4:0],G[5:3]}, byte1={G[2:0],B[4:0]}; G SHALL be compared as G[5:1] (5 bits).
REQ-018 A pixel counts as colour C when C >= other+COLOR_THRESH for both other channels (unsigned, 6-bit compare, no wrap); else counted as nothing.
REQ-019 Red/green/blue counters SHALL be wide enough for N_FRAMES*CAM_SCREEN_X*CAM_SCREEN_Y without overflow.
REQ-020 Column counter SHALL advance per completed pixel and clear on href falling; line counter SHALL advance on href falling.
REQ-021 On vsync rising in CAPTURE: if column count at any href fall != CAM_SCREEN_X or line count != CAM_SCREEN_Y, pulse error, res=000, -> IDLE; else increment frame count; if frame count < N_FRAMES -> WAIT_VS, else -> EVAL.
REQ-022 EVAL: the strictly largest counter wins if it exceeds 1/4 of counted pixels (shift by 2); ties or below threshold give 000; EVAL SHALL last exactly 1 cycle.
REQ-023 REPORT: update res, pulse done for 1 cycle, -> IDLE; res SHALL hold until next done or error.
REQ-024 init while busy SHALL be ignored; an odd trailing byte at href fall SHALL be discarded and flag a width error.

Reset
REQ-025 rst=0 SHALL asynchronously force IDLE, res=000, busy=0, done=0, error=0, all counters and synchronisers cleared, including mid-frame.
REQ-026 After rst release, first valid frame start SHALL be a vsync falling edge seen in WAIT_VS.

Configuration
REQ-027 With CAM_ROI_EN defined, only pixels with ROI_X0<=col<=ROI_X1 and ROI_Y0<=line<=ROI_Y1 SHALL update colour counters and the counted-pixel total.
REQ-028 Without CAM_ROI_EN, every pixel SHALL be counted and ROI parameters SHALL be unused.

Structure
REQ-029 Package cam_pkg SHALL hold the res encodings, the state encoding, and RGB565 field bit positions.
REQ-030 Sub-module cam_sync_edge SHALL implement the synchronisers and pclk/href/vsync edge detection.

Verification
REQ-031 160x120 all-red frame (0xF800), N_FRAMES=1 -> done pulse, res=001, error=0.
REQ-032 Frame with 119 lines -> error pulse at vsync rise, res=000, busy drops next cycle.
REQ-033 N_FRAMES=2, frame1 all blue (0x001F), frame2 all green (0x07E0) -> res=000 (tie).
REQ-034 CAM_ROI_EN, ROI 40..119 x 30..89 red, rest blue -> res=001; same stimulus without macro -> res=100.
REQ-035 rst=0 mid-line during CAPTURE -> all outputs 0 immediately; next init plus valid grey frame (0x8410) -> res=000, done.
REQ-036 init held high during capture and reasserted in REPORT -> exactly one result per accepted init.
